// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the single memory slave.
// Handshake: access is raised with its address/data and held until ack is seen; ack is a
// one-cycle pulse and the transfer completes on the clock edge where access && ack.
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16
);
  localparam int BS_W = DATA_WIDTH / 8;

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out;
  logic [NUM_MASTERS-1:0]            m_access;
  logic [NUM_MASTERS-1:0]            m_wr_en;
  logic [NUM_MASTERS*BS_W-1:0]       m_bytesel;
  logic [NUM_MASTERS-1:0]            m_lock;
  logic [DATA_WIDTH-1:0]             m_data_in;
  logic [NUM_MASTERS-1:0]            m_ack;

  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_data_out;
  logic                              s_access;
  logic                              s_wr_en;
  logic [BS_W-1:0]                   s_bytesel;
  logic [DATA_WIDTH-1:0]             s_data_in;
  logic                              s_ack;

  logic [NUM_MASTERS-1:0]            grant;

  // The arbiter is the bus master toward the memory port.
  modport master (
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, s_data_in, s_ack,
    output m_data_in, m_ack, s_addr, s_data_out, s_access, s_wr_en, s_bytesel, grant
  );

  // Environment view: requesting masters plus the memory slave.
  modport slave (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, s_data_in, s_ack,
    input  m_data_in, m_ack, s_addr, s_data_out, s_access, s_wr_en, s_bytesel, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// N-master to one-slave memory bus arbiter: fixed-priority or round-robin selection,
// single outstanding transfer, and a bus lock for read-modify-write sequences.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int RR_MODE     = 0,
  localparam int IDX_W      = $clog2(NUM_MASTERS),
  localparam int BS_W       = DATA_WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus,
  output logic              dbg_state,
  output logic              dbg_lock_valid,
  output logic [IDX_W-1:0]  dbg_lock_owner,
  output logic [IDX_W-1:0]  dbg_rr_ptr
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       own_idx_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic                   lock_valid_q;
  logic [IDX_W-1:0]       lock_owner_q;

  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   owner_lock;
  logic [NUM_MASTERS-1:0] eligible;
  logic [IDX_W-1:0]       base;
  logic [IDX_W:0]         cand;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic [IDX_W-1:0]       rr_next;
  logic                   active;

  // Arbitration: a held lock narrows eligibility to the owner alone.
  always_comb begin
    owner_mask               = '0;
    owner_mask[lock_owner_q] = 1'b1;
    owner_lock               = |(bus.m_lock & owner_mask);
    eligible                 = lock_valid_q ? (bus.m_access & owner_mask) : bus.m_access;
    base                     = (RR_MODE != 0) ? rr_ptr_q : '0;
    cand                     = '0;
    win_found                = 1'b0;
    win_idx                  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, base} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
      if (!win_found && eligible[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = win_found;
    rr_next             = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      own_idx_q    <= '0;
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Lock ends once the owner stops asserting m_lock, whether or not it requests.
          if (lock_valid_q && !owner_lock) lock_valid_q <= 1'b0;
          if (win_found) begin
            grant_q   <= win_onehot;
            own_idx_q <= win_idx;
            rr_ptr_q  <= rr_next;
          end
        end
        ACTIVE: begin
          if (bus.s_ack) begin
            grant_q <= '0;
            if (|(bus.m_lock & grant_q)) begin
              lock_valid_q <= 1'b1;
              lock_owner_q <= own_idx_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ACTIVE;
      ACTIVE:  if (bus.s_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side signals are forced to zero outside a granted transfer.
  always_comb begin
    active         = (state_q == ACTIVE);
    bus.s_access   = active;
    bus.s_addr     = '0;
    bus.s_data_out = '0;
    bus.s_wr_en    = 1'b0;
    bus.s_bytesel  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (active && grant_q[i]) begin
        bus.s_addr     = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_data_out = bus.m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        bus.s_wr_en    = bus.m_wr_en[i];
        bus.s_bytesel  = bus.m_bytesel[i*BS_W +: BS_W];
      end
    end
    bus.m_ack      = (active && bus.s_ack) ? grant_q : '0;
    bus.m_data_in  = bus.s_data_in;
    bus.grant      = grant_q;
    dbg_state      = state_q;
    dbg_lock_valid = lock_valid_q;
    dbg_lock_owner = lock_owner_q;
    dbg_rr_ptr     = rr_ptr_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 2-master fixed-priority instance and a 3-master
// round-robin instance, with completed transfers scored against expected queues.
module tb_mem_bus_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  mem_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fx ();
  mem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rx ();

  logic       fx_dbg_state, fx_dbg_lock_valid;
  logic [0:0] fx_dbg_lock_owner, fx_dbg_rr_ptr;
  logic       rx_dbg_state, rx_dbg_lock_valid;
  logic [1:0] rx_dbg_lock_owner, rx_dbg_rr_ptr;

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fx (
    .clk(clk), .reset(reset), .bus(fx.master),
    .dbg_state(fx_dbg_state), .dbg_lock_valid(fx_dbg_lock_valid),
    .dbg_lock_owner(fx_dbg_lock_owner), .dbg_rr_ptr(fx_dbg_rr_ptr)
  );

  mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_rx (
    .clk(clk), .reset(reset), .bus(rx.master),
    .dbg_state(rx_dbg_state), .dbg_lock_valid(rx_dbg_lock_valid),
    .dbg_lock_owner(rx_dbg_lock_owner), .dbg_rr_ptr(rx_dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // {m_ack, grant, s_addr, s_wr_en, s_data_out, s_bytesel, m_data_in}
  logic [57:0] fx_exp_q[$];
  // {m_ack, grant, s_addr}
  logic [24:0] rx_exp_q[$];
  logic [57:0] fx_exp;
  logic [24:0] rx_exp;
  logic [2:0]  rx_prev = '0;

  function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (fx.s_access && fx.s_ack) begin
      check("fx_txn_expected", 64'(fx_exp_q.size() != 0), 64'd1);
      if (fx_exp_q.size() != 0) begin
        fx_exp = fx_exp_q.pop_front();
        check("fx_txn", 64'({fx.m_ack, fx.grant, fx.s_addr, fx.s_wr_en, fx.s_data_out,
                             fx.s_bytesel, fx.m_data_in}), 64'(fx_exp));
      end
    end
  end

  always @(negedge clk) begin
    if (rx.s_access && rx.s_ack) begin
      check("rx_txn_expected", 64'(rx_exp_q.size() != 0), 64'd1);
      if (rx_exp_q.size() != 0) begin
        rx_exp = rx_exp_q.pop_front();
        check("rr_txn", 64'({rx.m_ack, rx.grant, rx.s_addr}), 64'(rx_exp));
      end
      check("rr_no_repeat", 64'(rx.grant != rx_prev), 64'd1);
      rx_prev = rx.grant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    fx.m_addr = '0; fx.m_data_out = '0; fx.m_access = '0; fx.m_wr_en = '0;
    fx.m_bytesel = '0; fx.m_lock = '0; fx.s_data_in = '0; fx.s_ack = 1'b0;
    rx.m_addr = '0; rx.m_data_out = '0; rx.m_access = '0; rx.m_wr_en = '0;
    rx.m_bytesel = '0; rx.m_lock = '0; rx.s_data_in = '0; rx.s_ack = 1'b0;
  endtask

  task automatic fx_req(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic wr, input logic [1:0] bsel, input logic lock);
    fx.m_addr[m*AW +: AW]     = addr;
    fx.m_data_out[m*DW +: DW] = data;
    fx.m_wr_en[m]             = wr;
    fx.m_bytesel[m*2 +: 2]    = bsel;
    fx.m_lock[m]              = lock;
    fx.m_access[m]            = 1'b1;
  endtask

  task automatic fx_drop(input int m);
    fx.m_access[m]            = 1'b0;
    fx.m_lock[m]              = 1'b0;
    fx.m_wr_en[m]             = 1'b0;
    fx.m_addr[m*AW +: AW]     = '0;
    fx.m_data_out[m*DW +: DW] = '0;
    fx.m_bytesel[m*2 +: 2]    = '0;
  endtask

  task automatic fx_push(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic wr, input logic [1:0] bsel, input logic [DW-1:0] rdata);
    logic [1:0] g;
    g    = '0;
    g[m] = 1'b1;
    fx_exp_q.push_back({g, g, addr, wr, data, bsel, rdata});
  endtask

  // Called just after a rising edge with the transfer active; returns just after the ack edge.
  task automatic fx_ack(input logic [DW-1:0] rdata);
    fx.s_ack     = 1'b1;
    fx.s_data_in = rdata;
    step();
    fx.s_ack     = 1'b0;
    fx.s_data_in = '0;
  endtask

  task automatic rx_wait_and_ack(input int budget);
    int n;
    n = 0;
    while (!rx.s_access && n < budget) begin
      step();
      n++;
    end
    check("rr_grant_wait", 64'(rx.s_access), 64'd1);
    rx.s_ack = 1'b1;
    step();
    rx.s_ack = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    init_inputs();
    #1 reset = 1'b1;
    #1;
    check("rst_s_access", 64'(fx.s_access), 64'd0);
    check("rst_grant", 64'(fx.grant), 64'd0);
    check("rst_m_ack", 64'(fx.m_ack), 64'd0);
    check("rst_lock_valid", 64'(fx_dbg_lock_valid), 64'd0);
    check("rst_rr_ptr", 64'(rx_dbg_rr_ptr), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Single read from master 1, acked three cycles after the request.
    fx_push(1, 19'h12345, 16'h0, 1'b0, 2'b00, 16'hBEEF);
    fx_req(1, 19'h12345, 16'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    check("t1_pre_grant", 64'(fx.s_access), 64'd0);
    step();
    check("t1_s_access", 64'(fx.s_access), 64'd1);
    check("t1_s_addr", 64'(fx.s_addr), 64'h12345);
    check("t1_grant", 64'(fx.grant), 64'b10);
    step();
    check("t1_no_early_ack", 64'(fx.m_ack), 64'd0);
    step();
    check("t1_no_early_ack2", 64'(fx.m_ack), 64'd0);
    fx_ack(16'hBEEF);
    fx_drop(1);
    @(negedge clk);
    check("t1_idle_s_access", 64'(fx.s_access), 64'd0);
    check("t1_idle_grant", 64'(fx.grant), 64'd0);
    check("t1_idle_s_addr", 64'(fx.s_addr), 64'd0);

    // Simultaneous requests: grant 01, idle gap, then 10.
    step();
    fx_push(0, 19'h00100, 16'h0, 1'b0, 2'b00, 16'h1111);
    fx_push(1, 19'h00200, 16'h0, 1'b0, 2'b00, 16'h2222);
    fx_req(0, 19'h00100, 16'h0, 1'b0, 2'b00, 1'b0);
    fx_req(1, 19'h00200, 16'h0, 1'b0, 2'b00, 1'b0);
    step();
    check("t2_grant_first", 64'(fx.grant), 64'b01);
    fx_ack(16'h1111);
    fx_drop(0);
    @(negedge clk);
    check("t2_idle_gap", 64'(fx.grant), 64'b00);
    step();
    check("t2_grant_second", 64'(fx.grant), 64'b10);
    fx_ack(16'h2222);
    fx_drop(1);

    // Byte write from master 0.
    step();
    fx_push(0, 19'h00042, 16'h00AA, 1'b1, 2'b01, 16'h0);
    fx_req(0, 19'h00042, 16'h00AA, 1'b1, 2'b01, 1'b0);
    step();
    check("t3_wr_en", 64'(fx.s_wr_en), 64'd1);
    check("t3_bytesel", 64'(fx.s_bytesel), 64'b01);
    check("t3_data_out", 64'(fx.s_data_out), 64'h00AA);
    fx_ack(16'h0);
    fx_drop(0);
    @(negedge clk);
    check("t3_wr_en_clr", 64'(fx.s_wr_en), 64'd0);
    check("t3_bytesel_clr", 64'(fx.s_bytesel), 64'd0);
    check("t3_data_out_clr", 64'(fx.s_data_out), 64'd0);

    // Locked read by master 1 holds off master 0 until master 1's unlocked write.
    step();
    fx_push(1, 19'h00300, 16'h0, 1'b0, 2'b00, 16'h3333);
    fx_push(1, 19'h00300, 16'h3334, 1'b1, 2'b11, 16'h0);
    fx_push(0, 19'h00400, 16'h0, 1'b0, 2'b00, 16'h4444);
    fx_req(1, 19'h00300, 16'h0, 1'b0, 2'b00, 1'b1);
    step();
    check("t4_grant_locked_rd", 64'(fx.grant), 64'b10);
    fx_req(0, 19'h00400, 16'h0, 1'b0, 2'b00, 1'b0);
    fx_ack(16'h3333);
    fx_req(1, 19'h00300, 16'h3334, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    check("t4_lock_set", 64'(fx_dbg_lock_valid), 64'd1);
    check("t4_lock_owner", 64'(fx_dbg_lock_owner), 64'd1);
    step();
    check("t4_owner_regrant", 64'(fx.grant), 64'b10);
    check("t4_lock_cleared", 64'(fx_dbg_lock_valid), 64'd0);
    fx_ack(16'h0);
    fx_drop(1);
    step();
    check("t4_waiter_after", 64'(fx.grant), 64'b01);
    fx_ack(16'h4444);
    fx_drop(0);

    // Lock abandoned: owner drops access and lock after its locked transfer.
    step();
    fx_push(1, 19'h00500, 16'h0, 1'b0, 2'b00, 16'h5555);
    fx_req(1, 19'h00500, 16'h0, 1'b0, 2'b00, 1'b1);
    step();
    fx_ack(16'h5555);
    fx_drop(1);
    @(negedge clk);
    check("t5_lock_held", 64'(fx_dbg_lock_valid), 64'd1);
    step();
    check("t5_lock_abandon", 64'(fx_dbg_lock_valid), 64'd0);

    // s_ack while idle is ignored.
    fx.s_ack     = 1'b1;
    fx.s_data_in = 16'hDEAD;
    @(negedge clk);
    check("t6_idle_ack_m_ack", 64'(fx.m_ack), 64'd0);
    check("t6_idle_ack_access", 64'(fx.s_access), 64'd0);
    step();
    fx.s_ack     = 1'b0;
    fx.s_data_in = '0;
    @(negedge clk);
    check("t6_still_idle", 64'(fx.s_access), 64'd0);

    // Asynchronous reset while a transfer is active; the request stays pending.
    step();
    fx_push(0, 19'h00600, 16'h0, 1'b0, 2'b00, 16'h6666);
    fx_req(0, 19'h00600, 16'h0, 1'b0, 2'b00, 1'b0);
    step();
    check("t7_active", 64'(fx.s_access), 64'd1);
    @(negedge clk);
    #1 fx.s_ack = 1'b1;
    #1;
    check("t7_ack_comb", 64'(fx.m_ack), 64'b01);
    reset = 1'b1;
    #1;
    check("t7_rst_access", 64'(fx.s_access), 64'd0);
    check("t7_rst_grant", 64'(fx.grant), 64'd0);
    check("t7_rst_m_ack", 64'(fx.m_ack), 64'd0);
    fx.s_ack = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t7_post_release_idle", 64'(fx.s_access), 64'd0);
    step();
    check("t7_regrant", 64'(fx.grant), 64'b01);
    fx_ack(16'h6666);
    fx_drop(0);

    // Round-robin with three masters requesting continuously.
    step();
    rx.m_addr = {19'h00103, 19'h00102, 19'h00101};
    rx_exp_q.push_back({3'b001, 3'b001, 19'h00101});
    rx_exp_q.push_back({3'b010, 3'b010, 19'h00102});
    rx_exp_q.push_back({3'b100, 3'b100, 19'h00103});
    rx_exp_q.push_back({3'b001, 3'b001, 19'h00101});
    rx.m_access = 3'b111;
    for (int k = 0; k < 4; k++) rx_wait_and_ack(8);
    rx.m_access = '0;

    @(negedge clk);
    check("fx_q_drained", 64'(fx_exp_q.size()), 64'd0);
    check("rx_q_drained", 64'(rx_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised N-master to single-slave memory bus arbiter. It merges the core's instruction and data buses, plus future DMA or debug masters, onto one external memory port. Every master and the slave use the core's access/ack bus protocol: access held until ack, ack a single-cycle pulse. Supports fixed-priority or round-robin selection, plus a bus-lock mode for locked read-modify-write sequences.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8); index 0 is highest priority in fixed mode.
ADDR_WIDTH, 19, word address width; addresses span [ADDR_WIDTH:1].
DATA_WIDTH, 16, data bus width; bytesel width is DATA_WIDTH/8.
RR_MODE, 0, 0 = fixed priority, 1 = round-robin.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master word address; master i occupies slice i
m_data_out  in  NUM_MASTERS*DATA_WIDTH  per-master write data
m_access  in  NUM_MASTERS  per-master request, held until that master's ack
m_wr_en  in  NUM_MASTERS  per-master write enable
m_bytesel  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte selects
m_lock  in  NUM_MASTERS  per-master lock request, sampled at ack
m_data_in  out  DATA_WIDTH  read data, s_data_in broadcast to all masters
m_ack  out  NUM_MASTERS  per-master one-cycle ack
s_addr  out  ADDR_WIDTH  slave address
s_data_out  out  DATA_WIDTH  slave write data
s_access  out  1  slave request
s_wr_en  out  1  slave write enable
s_bytesel  out  DATA_WIDTH/8  slave byte selects
s_data_in  in  DATA_WIDTH  slave read data
s_ack  in  1  slave ack
grant  out  NUM_MASTERS  one-hot registered current owner; 0 when idle

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state IDLE; grant=0; rr_ptr=0; lock_valid=0; lock_owner=0; s_access=0; m_ack=0.
- While s_access=0, s_addr, s_data_out, s_wr_en and s_bytesel are 0.
- States: IDLE and ACTIVE.
- IDLE: if any eligible m_access is high, register the winner into grant and move to ACTIVE. Otherwise stay in IDLE.
  - Eligible = all masters when lock_valid=0; only lock_owner when lock_valid=1.
  - Latency: request to s_access high is exactly 1 cycle.
- Fixed mode: the lowest-index eligible requester wins.
- Round-robin mode: search begins at rr_ptr and wraps modulo NUM_MASTERS. On each grant, rr_ptr <= winner+1, with wrap to 0 when winner = NUM_MASTERS-1.
- ACTIVE: s_access=1. s_addr, s_data_out, s_wr_en and s_bytesel are muxed combinationally from the granted master. m_ack[g] = s_ack (combinational). Every other m_ack bit is 0.
- On s_ack in ACTIVE: return to IDLE and clear grant. This guarantees one idle cycle between transactions, so a master's access released after ack is never re-granted twice.
- Lock, set: on the ack cycle, if m_lock[g]=1, then lock_valid <= 1 and lock_owner <= g.
- Lock, clear: in IDLE, if lock_valid=1 and the owner's access is high with lock low, lock_valid clears. The owner's transaction in that same cycle is still granted.
- Lock, abandon: in IDLE, if lock_valid=1 and the owner has access low and lock low, lock_valid clears.
- While locked, other requesters wait; their requests are not dropped.
- Masters must not drop m_access before ack. If the granted master's access falls while ACTIVE, the arbiter still completes on s_ack (the slave owns the cycle).
- s_ack while IDLE is ignored, and every m_ack bit stays 0.
- Simultaneous requests in IDLE are resolved in a single cycle. Non-winning requests stay pending.
- Reset mid-transaction: s_access, m_ack and grant drop immediately and asynchronously. No ack is issued for the aborted transaction.
- m_data_in = s_data_in at all times. It is valid only in the cycle where the master's m_ack is high.

Test Plan:
- Single read, fixed mode: master 1 requests addr 0x12345, slave acks 3 cycles later with 0xBEEF -> s_access rises 1 cycle after request; s_addr=0x12345; m_ack[1] pulses exactly with s_ack; m_data_in=0xBEEF on that cycle; m_ack[0]=0.
- Simultaneous requests, fixed mode: masters 0 and 1 raise access together -> master 0 granted first; one IDLE cycle; then master 1 granted; grant sequence 01, 00, 10.
- Round-robin, RR_MODE=1, NUM_MASTERS=3: all three masters request continuously -> grant order 0, 1, 2, 0; no master is granted twice in a row.
- Lock: master 1 performs a locked read (m_lock=1) while master 0 requests -> master 1's unlocked write is granted next, master 0 only after it; lock_valid clears on that write.
- Byte write: master 0 writes 0x00AA with bytesel=01 -> s_wr_en=1, s_bytesel=01, s_data_out=0x00AA; outputs return to 0 after ack.
- Async reset during ACTIVE, before ack -> s_access, grant and m_ack are 0 without a clock edge; after release, a pending request is granted 1 cycle later.
